// File: rtl/aes128_arb_ctrl_if.sv
// Requester A/B handshakes, AES-128 core control/status and error counter
// for aes128_arb_ctrl. The slave modport is the controller's view.
interface aes128_arb_ctrl_if;
   logic         a_req_valid;
   logic         a_req_ready;
   logic [127:0] a_req_pt;
   logic [127:0] a_req_key;
   logic         a_rsp_valid;
   logic         a_rsp_ready;
   logic [127:0] a_rsp_data;
   logic         a_rsp_err;

   logic         b_req_valid;
   logic         b_req_ready;
   logic [127:0] b_req_pt;
   logic [127:0] b_req_key;
   logic         b_rsp_valid;
   logic         b_rsp_ready;
   logic [127:0] b_rsp_data;
   logic         b_rsp_err;

   logic         fault_en;
   logic         core_start;
   logic [127:0] core_plaintext;
   logic [127:0] core_key;
   logic         core_fault_inject;
   logic [127:0] core_ciphertext;
   logic         core_done;
   logic         core_busy;
   logic [7:0]   err_count;

   modport slave (
      input  a_req_valid, a_req_pt, a_req_key, a_rsp_ready,
      input  b_req_valid, b_req_pt, b_req_key, b_rsp_ready,
      input  fault_en, core_ciphertext, core_done, core_busy,
      output a_req_ready, a_rsp_valid, a_rsp_data, a_rsp_err,
      output b_req_ready, b_rsp_valid, b_rsp_data, b_rsp_err,
      output core_start, core_plaintext, core_key, core_fault_inject, err_count
   );

   modport master (
      output a_req_valid, a_req_pt, a_req_key, a_rsp_ready,
      output b_req_valid, b_req_pt, b_req_key, b_rsp_ready,
      output fault_en, core_ciphertext, core_done, core_busy,
      input  a_req_ready, a_rsp_valid, a_rsp_data, a_rsp_err,
      input  b_req_ready, b_rsp_valid, b_rsp_data, b_rsp_err,
      input  core_start, core_plaintext, core_key, core_fault_inject, err_count
   );
endinterface

// File: rtl/aes128_arb_ctrl.sv
// Two-requester round-robin front end for a single AES-128 core: one request
// in flight, START pulse, bounded WAIT with timeout error, per-requester RESP.
module aes128_arb_ctrl #(
   parameter int unsigned TIMEOUT_CYCLES = 32
) (
   input  logic              clk,
   input  logic              rst,
   aes128_arb_ctrl_if.slave  bus
);
   typedef enum logic [1:0] {ST_IDLE, ST_START, ST_WAIT, ST_RESP} state_t;

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

   state_t       state_q, state_d;
   logic         last_b_q, last_b_d;
   logic         gnt_b_q, gnt_b_d;
   logic [127:0] pt_q, pt_d;
   logic [127:0] key_q, key_d;
   logic [127:0] a_data_q, a_data_d;
   logic [127:0] b_data_q, b_data_d;
   logic         a_err_q, a_err_d;
   logic         b_err_q, b_err_d;
   logic [7:0]   cnt_q, cnt_d;
   logic [7:0]   err_cnt_q, err_cnt_d;
   logic         pick_b, a_rdy, b_rdy, rsp_ack;

   always_comb begin
      state_d   = state_q;
      last_b_d  = last_b_q;
      gnt_b_d   = gnt_b_q;
      pt_d      = pt_q;
      key_d     = key_q;
      a_data_d  = a_data_q;
      b_data_d  = b_data_q;
      a_err_d   = a_err_q;
      b_err_d   = b_err_q;
      cnt_d     = cnt_q;
      err_cnt_d = err_cnt_q;
      a_rdy     = 1'b0;
      b_rdy     = 1'b0;
      // B wins when alone, or when both contend and A was granted last
      pick_b    = bus.b_req_valid && (!bus.a_req_valid || !last_b_q);
      rsp_ack   = gnt_b_q ? bus.b_rsp_ready : bus.a_rsp_ready;

      unique case (state_q)
         ST_IDLE: begin
            if (!bus.core_busy && (bus.a_req_valid || bus.b_req_valid)) begin
               a_rdy   = !pick_b;
               b_rdy   = pick_b;
               gnt_b_d = pick_b;
               pt_d    = pick_b ? bus.b_req_pt  : bus.a_req_pt;
               key_d   = pick_b ? bus.b_req_key : bus.a_req_key;
               state_d = ST_START;
            end
         end
         ST_START: begin
            cnt_d   = '0;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            cnt_d = cnt_q + 8'd1;
            // core_done takes priority over a coincident timeout
            if (bus.core_done) begin
               if (gnt_b_q) begin
                  b_data_d = bus.core_ciphertext;
                  b_err_d  = 1'b0;
               end else begin
                  a_data_d = bus.core_ciphertext;
                  a_err_d  = 1'b0;
               end
               state_d = ST_RESP;
            end else if (cnt_q == CNT_LAST) begin
               if (gnt_b_q) begin
                  b_data_d = '0;
                  b_err_d  = 1'b1;
               end else begin
                  a_data_d = '0;
                  a_err_d  = 1'b1;
               end
               if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            if (rsp_ack) begin
               last_b_d = gnt_b_q;
               state_d  = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         last_b_q  <= 1'b1;
         gnt_b_q   <= 1'b0;
         pt_q      <= '0;
         key_q     <= '0;
         a_data_q  <= '0;
         b_data_q  <= '0;
         a_err_q   <= 1'b0;
         b_err_q   <= 1'b0;
         cnt_q     <= '0;
         err_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         last_b_q  <= last_b_d;
         gnt_b_q   <= gnt_b_d;
         pt_q      <= pt_d;
         key_q     <= key_d;
         a_data_q  <= a_data_d;
         b_data_q  <= b_data_d;
         a_err_q   <= a_err_d;
         b_err_q   <= b_err_d;
         cnt_q     <= cnt_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign bus.a_req_ready       = a_rdy;
   assign bus.b_req_ready       = b_rdy;
   assign bus.a_rsp_valid       = (state_q == ST_RESP) && !gnt_b_q;
   assign bus.b_rsp_valid       = (state_q == ST_RESP) && gnt_b_q;
   assign bus.a_rsp_data        = a_data_q;
   assign bus.b_rsp_data        = b_data_q;
   assign bus.a_rsp_err         = a_err_q;
   assign bus.b_rsp_err         = b_err_q;
   assign bus.core_start        = (state_q == ST_START);
   assign bus.core_plaintext    = pt_q;
   assign bus.core_key          = key_q;
   assign bus.core_fault_inject = bus.fault_en && (state_q == ST_WAIT);
   assign bus.err_count         = err_cnt_q;
endmodule
